// File: rtl/onchip_mem_loader.sv
// Boot-image loader: packs a byte stream into little-endian words, writes them to
// on-chip program memory from address 0, then reads them back and checks a sum.
module onchip_mem_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [12:0]       word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              cpu_reset_req,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_VERIFY  = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  widx_q, widx_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       wsum_q, wsum_d;
    logic [31:0]       rsum_q, rsum_d;
    logic              rd_vld_q, rd_vld_d;
    logic              in_ready_q, in_ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [31:0]       checksum_q, checksum_d;
    logic [3:0]        be_q;

    logic [CNT_W-1:0]  n_clamped_c;
    logic [CNT_W-1:0]  idx_inc_c;
    logic [4:0]        lane_sh_c;
    logic [31:0]       word_next_c;

    // Clamp the requested length and build the word with the incoming byte in its lane.
    always_comb begin
        if (32'(word_count) > DEPTH) n_clamped_c = CNT_W'(DEPTH);
        else                         n_clamped_c = CNT_W'(word_count);
        idx_inc_c   = widx_q + CNT_W'(1);
        lane_sh_c   = {bidx_q, 3'b000};
        word_next_c = (word_q & ~(32'h0000_00FF << lane_sh_c)) | (32'(in_data) << lane_sh_c);
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        widx_d     = widx_q;
        bidx_d     = bidx_q;
        word_d     = word_q;
        wsum_d     = wsum_q;
        rsum_d     = rd_vld_q ? rsum_q + mem_readdata : rsum_q;
        rd_vld_d   = 1'b0;
        in_ready_d = 1'b0;
        addr_d     = addr_q;
        cs_d       = 1'b0;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        error_d    = error_q;
        checksum_d = checksum_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_clamped_c;
                    widx_d  = '0;
                    bidx_d  = '0;
                    wsum_d  = '0;
                    rsum_d  = '0;
                    error_d = 1'b0;
                    if (n_clamped_c == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_COLLECT;
                        in_ready_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    word_d = word_next_c;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d    = S_WRITE;
                        in_ready_d = 1'b0;
                        cs_d       = 1'b1;
                        we_d       = 1'b1;
                        addr_d     = widx_q[ADDR_W-1:0];
                        wdata_d    = word_next_c;
                    end
                end
            end
            S_WRITE: begin
                wsum_d = wsum_q + wdata_q;
                if (idx_inc_c == n_q) begin
                    state_d = S_VERIFY;
                    widx_d  = '0;
                    addr_d  = '0;
                    cs_d    = 1'b1;
                end else begin
                    state_d    = S_COLLECT;
                    widx_d     = idx_inc_c;
                    in_ready_d = 1'b1;
                end
            end
            S_VERIFY: begin
                // The read of widx_q is on the bus now; its data is summed next cycle.
                rd_vld_d = 1'b1;
                widx_d   = idx_inc_c;
                if (idx_inc_c == n_q) begin
                    state_d = S_DRAIN;
                end else begin
                    cs_d   = 1'b1;
                    addr_d = idx_inc_c[ADDR_W-1:0];
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d     = 1'b1;
                error_d    = (rsum_q != wsum_q);
                checksum_d = wsum_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            widx_q     <= '0;
            bidx_q     <= '0;
            word_q     <= '0;
            wsum_q     <= '0;
            rsum_q     <= '0;
            rd_vld_q   <= 1'b0;
            in_ready_q <= 1'b0;
            addr_q     <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            checksum_q <= '0;
            be_q       <= 4'h0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            widx_q     <= widx_d;
            bidx_q     <= bidx_d;
            word_q     <= word_d;
            wsum_q     <= wsum_d;
            rsum_q     <= rsum_d;
            rd_vld_q   <= rd_vld_d;
            in_ready_q <= in_ready_d;
            addr_q     <= addr_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            checksum_q <= checksum_d;
            be_q       <= 4'hF;
        end
    end

    assign in_ready       = in_ready_q;
    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_chipselect = cs_q;
    assign mem_write      = we_q;
    assign mem_writedata  = wdata_q;
    assign cpu_reset_req  = busy_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign checksum       = checksum_q;

endmodule

// File: tb/tb_onchip_mem_loader.sv
// Directed bench for onchip_mem_loader with a one-cycle-latency memory model.
module tb_onchip_mem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [12:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        cpu_reset_req;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    onchip_mem_loader #(.ADDR_W(12), .DEPTH(4096)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .cpu_reset_req(cpu_reset_req), .busy(busy), .done(done),
        .error(error), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem    [0:4095];
    logic [11:0] wr_addr[0:8191];
    logic [31:0] wr_data[0:8191];
    logic [3:0]  wr_be  [0:8191];
    logic [11:0] rd_addr[0:8191];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          cs_cnt = 0;
    logic        corrupt = 1'b0;
    logic [7:0]  src    [0:16383];
    logic        err_at1;

    // Memory model plus access log
    always @(posedge clk) begin
        if (mem_chipselect) begin
            cs_cnt = cs_cnt + 1;
            if (mem_write) begin
                mem[mem_address] = mem_writedata;
                if (wr_cnt < 8192) begin
                    wr_addr[wr_cnt] = mem_address;
                    wr_data[wr_cnt] = mem_writedata;
                    wr_be[wr_cnt]   = mem_byteenable;
                end
                wr_cnt = wr_cnt + 1;
            end else begin
                mem_readdata <= mem[mem_address] ^ {31'd0, (corrupt && mem_address == 12'd1)};
                if (rd_cnt < 8192) rd_addr[rd_cnt] = mem_address;
                rd_cnt = rd_cnt + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one load from src[]; c counts cycles after the start cycle.
    task automatic do_load(input int wc, input bit gaps, input bit extra_starts,
                           input int abort_words, output int done_at, output int done_pulses);
        int  n;
        int  ptr;
        int  c;
        int  budget;
        int  wr0;
        bit  hs;
        bit  vstart;
        n = (wc > 4096) ? 4096 : wc;
        ptr = 0; c = 0; done_at = -1; done_pulses = 0; vstart = 1'b0;
        budget = 20 * n + 60;
        wr0 = wr_cnt;
        word_count = 13'(wc);
        start = 1'b1;
        in_data = src[0];
        in_valid = (n > 0);
        while (c < budget) begin
            hs = in_ready && in_valid;
            step();
            c++;
            start = 1'b0;
            if (hs) ptr++;
            if (c == 1) err_at1 = error;
            if (done) begin
                done_pulses++;
                if (done_at < 0) done_at = c;
            end
            if (abort_words > 0 && (wr_cnt - wr0) >= abort_words) begin
                reset_n = 1'b0;
                #1;
                in_valid = 1'b0;
                return;
            end
            if (extra_starts) begin
                if (c == 2) start = 1'b1;
                if (mem_chipselect && !mem_write && !vstart) begin
                    start = 1'b1;
                    vstart = 1'b1;
                end
            end
            in_data = (ptr < 16384) ? src[ptr] : 8'h00;
            in_valid = (ptr < 4 * n) ? (gaps ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            if (done_at >= 0 && c > done_at + 4) break;
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; word_count = '0; in_data = '0; in_valid = 1'b0;
        mem_readdata = '0;
        #12;
        n_checks++;
        if ({in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error} !== 7'd0) begin
            n_errors++; $display("FAIL reset_ctrl: got %b required 0000000",
                {in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error});
        end
        n_checks++;
        if ({mem_address, mem_byteenable, mem_writedata, checksum} !== 80'd0) begin
            n_errors++; $display("FAIL reset_data: addr=%h be=%h wd=%h cs=%h required all 0",
                mem_address, mem_byteenable, mem_writedata, checksum);
        end
        step();
        reset_n = 1'b1;
        step(); step();
    endtask

    task automatic single_word_checks(input string tag);
        int da, dp, wr0, rd0;
        src[0] = 8'h78; src[1] = 8'h56; src[2] = 8'h34; src[3] = 8'h12;
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_load(1, 1'b0, 1'b0, 0, da, dp);
        n_checks++;
        if (da !== 9) begin n_errors++; $display("FAIL %s done_latency: got %0d required 9", tag, da); end
        n_checks++;
        if (wr_cnt - wr0 !== 1 || wr_addr[wr0] !== 12'd0 || wr_data[wr0] !== 32'h1234_5678 || wr_be[wr0] !== 4'hF) begin
            n_errors++; $display("FAIL %s write: cnt=%0d addr=%h data=%h be=%h required 1/000/12345678/f",
                tag, wr_cnt - wr0, wr_addr[wr0], wr_data[wr0], wr_be[wr0]);
        end
        n_checks++;
        if (rd_cnt - rd0 !== 1 || rd_addr[rd0] !== 12'd0) begin
            n_errors++; $display("FAIL %s read: cnt=%0d addr=%h required 1/000", tag, rd_cnt - rd0, rd_addr[rd0]);
        end
        n_checks++;
        if (checksum !== 32'h1234_5678 || error !== 1'b0 || dp !== 1) begin
            n_errors++; $display("FAIL %s result: checksum=%h error=%b dones=%0d required 12345678/0/1",
                tag, checksum, error, dp);
        end
    endtask

    task automatic test_single_word();
        single_word_checks("single");
        n_checks++;
        if (busy !== 1'b0 || cpu_reset_req !== 1'b0) begin
            n_errors++; $display("FAIL single_idle: busy=%b cpu_reset_req=%b required 0/0", busy, cpu_reset_req);
        end
    endtask

    task automatic test_gaps();
        int da, dp, wr0;
        for (int i = 0; i < 12; i++) src[i] = 8'(i + 1);
        wr0 = wr_cnt;
        do_load(3, 1'b1, 1'b0, 0, da, dp);
        n_checks++;
        if (wr_cnt - wr0 !== 3 || wr_addr[wr0] !== 12'd0 || wr_addr[wr0+1] !== 12'd1 || wr_addr[wr0+2] !== 12'd2) begin
            n_errors++; $display("FAIL gaps_addr: cnt=%0d addrs=%h,%h,%h required 3/0,1,2",
                wr_cnt - wr0, wr_addr[wr0], wr_addr[wr0+1], wr_addr[wr0+2]);
        end
        n_checks++;
        if (wr_data[wr0] !== 32'h0403_0201 || wr_data[wr0+1] !== 32'h0807_0605 || wr_data[wr0+2] !== 32'h0C0B_0A09) begin
            n_errors++; $display("FAIL gaps_data: got %h %h %h required 04030201 08070605 0c0b0a09",
                wr_data[wr0], wr_data[wr0+1], wr_data[wr0+2]);
        end
        n_checks++;
        if (checksum !== 32'h1815_120F || error !== 1'b0 || dp !== 1) begin
            n_errors++; $display("FAIL gaps_sum: checksum=%h error=%b dones=%0d required 1815120f/0/1", checksum, error, dp);
        end
    endtask

    task automatic test_corrupt();
        int da, dp;
        src[0] = 8'hFF; src[1] = 8'hFF; src[2] = 8'hFF; src[3] = 8'hFF;
        src[4] = 8'h02; src[5] = 8'h00; src[6] = 8'h00; src[7] = 8'h00;
        corrupt = 1'b1;
        do_load(2, 1'b0, 1'b0, 0, da, dp);
        corrupt = 1'b0;
        n_checks++;
        if (error !== 1'b1 || checksum !== 32'h0000_0001 || da !== 15) begin
            n_errors++; $display("FAIL corrupt_result: error=%b checksum=%h done_at=%0d required 1/00000001/15",
                error, checksum, da);
        end
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (error !== 1'b1) begin n_errors++; $display("FAIL corrupt_hold: error=%b required 1", error); end
    endtask

    task automatic test_start_busy();
        int da, dp, wr0, rd0;
        for (int i = 0; i < 8; i++) src[i] = 8'(8'h10 + i);
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_load(2, 1'b0, 1'b1, 0, da, dp);
        n_checks++;
        if (err_at1 !== 1'b0) begin n_errors++; $display("FAIL start_clears_error: error=%b required 0", err_at1); end
        n_checks++;
        if (dp !== 1 || da !== 15) begin
            n_errors++; $display("FAIL busy_start_done: dones=%0d done_at=%0d required 1/15", dp, da);
        end
        n_checks++;
        if (wr_cnt - wr0 !== 2 || rd_cnt - rd0 !== 2 || checksum !== 32'h2A28_2624 || error !== 1'b0) begin
            n_errors++; $display("FAIL busy_start_access: wr=%0d rd=%0d checksum=%h error=%b required 2/2/2a282624/0",
                wr_cnt - wr0, rd_cnt - rd0, checksum, error);
        end
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL busy_start_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid();
        int da, dp;
        for (int i = 0; i < 20; i++) src[i] = 8'(8'hA0 + i);
        do_load(5, 1'b0, 1'b0, 2, da, dp);
        n_checks++;
        if ({in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error} !== 7'd0) begin
            n_errors++; $display("FAIL midreset_ctrl: got %b required 0000000",
                {in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error});
        end
        n_checks++;
        if (checksum !== 32'd0 || mem_writedata !== 32'd0 || mem_address !== 12'd0) begin
            n_errors++; $display("FAIL midreset_data: checksum=%h wd=%h addr=%h required 0/0/0",
                checksum, mem_writedata, mem_address);
        end
        n_checks++;
        if (da !== -1) begin n_errors++; $display("FAIL midreset_no_done: done_at=%0d required -1", da); end
        step();
        reset_n = 1'b1;
        step(); step();
        single_word_checks("after_reset");
    endtask

    task automatic test_boundary();
        int da, dp, wr0, rd0, cs0;
        logic [31:0] exp_sum;
        logic [31:0] w;
        cs0 = cs_cnt;
        do_load(0, 1'b0, 1'b0, 0, da, dp);
        n_checks++;
        if (da !== 2 || cs_cnt - cs0 !== 0 || checksum !== 32'd0 || error !== 1'b0) begin
            n_errors++; $display("FAIL zero_len: done_at=%0d cs=%0d checksum=%h error=%b required 2/0/0/0",
                da, cs_cnt - cs0, checksum, error);
        end
        exp_sum = '0;
        for (int i = 0; i < 16384; i++) src[i] = 8'(i * 7 + 3);
        for (int j = 0; j < 4096; j++) begin
            w = {src[4*j+3], src[4*j+2], src[4*j+1], src[4*j]};
            exp_sum = exp_sum + w;
        end
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_load(5000, 1'b0, 1'b0, 0, da, dp);
        n_checks++;
        if (wr_cnt - wr0 !== 4096 || wr_addr[wr0 + 4095] !== 12'hFFF || rd_cnt - rd0 !== 4096) begin
            n_errors++; $display("FAIL clamp_access: wr=%0d last=%h rd=%0d required 4096/fff/4096",
                wr_cnt - wr0, wr_addr[wr0 + 4095], rd_cnt - rd0);
        end
        n_checks++;
        if (da !== 24579 || dp !== 1) begin
            n_errors++; $display("FAIL clamp_latency: done_at=%0d dones=%0d required 24579/1", da, dp);
        end
        n_checks++;
        if (checksum !== exp_sum || error !== 1'b0) begin
            n_errors++; $display("FAIL clamp_sum: checksum=%h error=%b required %h/0", checksum, error, exp_sum);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gaps();
        test_corrupt();
        test_start_busy();
        test_reset_mid();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
